// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
// Packs decoded RV32I field bundles into 32-bit instruction words, range-checks
// each immediate, and tags every emitted word with a sequential IMEM word address.
// Two-stage pipeline: S1 capture register, S2 output register; full throughput.
module rv32i_instr_encoder #(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_format,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   input  logic                 addr_clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [ADDR_W-1:0]    out_addr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   // S1 capture register contents
   logic                 r_s1_valid;
   logic [2:0]           r_format;
   logic [6:0]           r_opcode;
   logic [4:0]           r_rd;
   logic [4:0]           r_rs1;
   logic [4:0]           r_rs2;
   logic [2:0]           r_funct3;
   logic [6:0]           r_funct7;
   logic [31:0]          r_imm;

   // S2 output register and bookkeeping
   logic                 r_out_valid;
   logic [31:0]          r_out_instr;
   logic [ADDR_W-1:0]    r_out_addr;
   logic                 r_out_err;
   logic [ERR_CNT_W-1:0] r_err_count;
   logic [ADDR_W-1:0]    r_addr;

   logic                 w_s2_free;
   logic                 w_accept;
   logic                 w_advance;
   logic                 w_fits12;
   logic                 w_fits13;
   logic                 w_fits21;
   logic                 w_legal;
   logic [31:0]          w_instr;

   // Handshake: S1 can refill in the same cycle it drains into S2
   assign w_s2_free = ~r_out_valid | out_ready;
   assign in_ready  = ~r_s1_valid | w_s2_free;
   assign w_accept  = in_valid & in_ready;
   assign w_advance = r_s1_valid & w_s2_free;

   // Sign-extension checks: the bits above the field's sign bit must all match it
   assign w_fits12 = (&r_imm[31:11]) | ~(|r_imm[31:11]);
   assign w_fits13 = (&r_imm[31:12]) | ~(|r_imm[31:12]);
   assign w_fits21 = (&r_imm[31:20]) | ~(|r_imm[31:20]);

   // Pack the S1 bundle into its RV32I layout and judge immediate legality
   always_comb begin
      w_instr = '0;
      w_legal = 1'b0;
      case (r_format)
         FMT_R: begin
            w_instr = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
            w_legal = 1'b1;
         end
         FMT_I: begin
            w_instr = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
            w_legal = w_fits12;
         end
         FMT_S: begin
            w_instr = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
            w_legal = w_fits12;
         end
         FMT_B: begin
            w_instr = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                       r_imm[4:1], r_imm[11], r_opcode};
            w_legal = w_fits13 & ~r_imm[0];
         end
         FMT_U: begin
            w_instr = {r_imm[31:12], r_rd, r_opcode};
            w_legal = ~(|r_imm[11:0]);
         end
         FMT_J: begin
            w_instr = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
            w_legal = w_fits21 & ~r_imm[0];
         end
         default: begin
            w_instr = '0;
            w_legal = 1'b0;
         end
      endcase
   end

   // S1 payload capture; no reset needed since r_s1_valid qualifies it
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_format <= in_format;
         r_opcode <= in_opcode;
         r_rd     <= in_rd;
         r_rs1    <= in_rs1;
         r_rs2    <= in_rs2;
         r_funct3 <= in_funct3;
         r_funct7 <= in_funct7;
         r_imm    <= in_imm;
      end
   end

   // S1 occupancy
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_s1_valid <= 1'b0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
      end else if (w_advance) begin
         r_s1_valid <= 1'b0;
      end
   end

   // S2 output register: load legal words, drop on sink acceptance
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_addr  <= BASE_ADDR;
      end else if (w_advance && w_legal) begin
         r_out_valid <= 1'b1;
         r_out_instr <= w_instr;
         r_out_addr  <= r_addr;
      end else if (w_s2_free) begin
         r_out_valid <= 1'b0;
      end
   end

   // Error pulse and saturating reject counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_out_err   <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_out_err <= w_advance & ~w_legal;
         if (w_advance && !w_legal && !(&r_err_count)) begin
            r_err_count <= ERR_CNT_W'(r_err_count + 1'b1);
         end
      end
   end

   // IMEM address counter; clear wins over increment, wraps silently
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_addr <= BASE_ADDR;
      end else if (addr_clear) begin
         r_addr <= BASE_ADDR;
      end else if (w_advance && w_legal) begin
         r_addr <= ADDR_W'(r_addr + 1'b1);
      end
   end

   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_addr  = r_out_addr;
   assign out_err   = r_out_err;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: directed known encodings, error handling,
// backpressure, address clear/reset, then randomized traffic against a
// transaction-level reference model (arithmetic encoder + in-order scoreboard).
module tb_rv32i_instr_encoder;

   localparam int unsigned       ADDR_W    = 8;
   localparam int unsigned       ERR_CNT_W = 8;
   localparam logic [ADDR_W-1:0] BASE      = 8'd3;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           in_format;
   logic [6:0]           in_opcode;
   logic [4:0]           in_rd;
   logic [4:0]           in_rs1;
   logic [4:0]           in_rs2;
   logic [2:0]           in_funct3;
   logic [6:0]           in_funct7;
   logic [31:0]          in_imm;
   logic                 addr_clear;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_instr;
   logic [ADDR_W-1:0]    out_addr;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_count;

   rv32i_instr_encoder #(
      .ADDR_W   (ADDR_W),
      .BASE_ADDR(BASE),
      .ERR_CNT_W(ERR_CNT_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_format (in_format),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .addr_clear(addr_clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .out_err   (out_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       instr;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   int                n_checks = 0;
   int                n_fail   = 0;
   exp_t              q[$];
   exp_t              mon_e;
   logic [ADDR_W-1:0] m_addr;
   int                m_err      = 0;
   int                m_err_seen = 0;
   bit                stim_done  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Legality from the signed value of the immediate
   function automatic bit ref_legal(input logic [2:0] fmt, input logic [31:0] imm);
      int s;
      s = $signed(imm);
      case (fmt)
         3'd0:       return 1'b1;
         3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
         3'd3:       return (s >= -4096) && (s <= 4094) && ((imm % 32'd2) == 32'd0);
         3'd4:       return (imm % 32'd4096) == 32'd0;
         3'd5:       return (s >= -1048576) && (s <= 1048574) && ((imm % 32'd2) == 32'd0);
         default:    return 1'b0;
      endcase
   endfunction

   // Instruction word built by shifting and masking the RV32I field layouts
   function automatic logic [31:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] imm);
      logic [31:0] mid;
      logic [31:0] dst;
      mid = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
      dst = 32'(rd) << 7;
      case (fmt)
         3'd0: return (32'(f7) << 25) | (32'(rs2) << 20) | mid | dst;
         3'd1: return ((imm & 32'hFFF) << 20) | mid | dst;
         3'd2: return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | mid
                      | ((imm & 32'h1F) << 7);
         3'd3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (32'(rs2) << 20) | mid | (((imm >> 1) & 32'hF) << 8)
                      | (((imm >> 11) & 32'h1) << 7);
         3'd4: return (imm & 32'hFFFFF000) | dst | 32'(op);
         3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | dst | 32'(op);
         default: return 32'h0;
      endcase
   endfunction

   // Present one bundle (called just after a rising edge) and wait for acceptance
   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
      bit done;
      done      = 1'b0;
      in_valid  = 1'b1;
      in_format = fmt;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_funct7 = f7;
      in_imm    = imm;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
            if (ref_legal(fmt, imm)) begin
               q.push_back('{ref_enc(fmt, op, rd, rs1, rs2, f3, f7, imm), m_addr});
               m_addr = ADDR_W'(m_addr + 1'b1);
            end else begin
               m_err++;
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   // Wait for the next delivered word and compare it directly
   task automatic expect_word(input string tag, input logic [31:0] ei, input logic [ADDR_W-1:0] ea);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            seen = 1'b1;
            check({tag, "_instr"}, out_instr, ei);
            check({tag, "_addr"}, 32'(out_addr), 32'(ea));
         end
      end
      if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] pick_boundary(input int i);
      case (i)
         0:  return 32'($signed(-2048));
         1:  return 32'd2047;
         2:  return 32'd2048;
         3:  return 32'($signed(-2049));
         4:  return 32'($signed(-4096));
         5:  return 32'd4094;
         6:  return 32'd4095;
         7:  return 32'd4096;
         8:  return 32'($signed(-4098));
         9:  return 32'($signed(-1048576));
         10: return 32'd1048574;
         11: return 32'd1048576;
         12: return 32'($signed(-1048578));
         13: return 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   task automatic send_random();
      logic [2:0]  fmt;
      logic [31:0] imm;
      int          k;
      k = int'($urandom_range(0, 15));
      fmt = (k < 14) ? 3'(k % 6) : 3'(k - 8);
      case ($urandom_range(0, 4))
         0: imm = $urandom;
         1: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
         2: imm = 32'(int'($urandom_range(0, 4194303)) - 2097152);
         3: imm = pick_boundary(int'($urandom_range(0, 14)));
         default: imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFFF000);
      endcase
      send(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), imm);
   endtask

   // Scoreboard: every delivered word must match the head of the expected queue
   always @(negedge clk) begin
      if (resetn) begin
         if (out_err) m_err_seen++;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_word", 32'(out_valid), 32'd0);
            end else begin
               mon_e = q.pop_front();
               check("mon_instr", out_instr, mon_e.instr);
               check("mon_addr", 32'(out_addr), 32'(mon_e.addr));
            end
         end
      end
   end

   logic [31:0] enc_a;
   logic [31:0] enc_w;
   int          exp_sat;

   initial begin
      resetn     = 1'b0;
      in_valid   = 1'b0;
      in_format  = '0;
      in_opcode  = '0;
      in_rd      = '0;
      in_rs1     = '0;
      in_rs2     = '0;
      in_funct3  = '0;
      in_funct7  = '0;
      in_imm     = '0;
      addr_clear = 1'b0;
      out_ready  = 1'b1;
      m_addr     = BASE;

      // Reset state
      idle(3);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 resetn = 1'b1;
      idle(1);

      // Known encodings and first-word latency
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      @(negedge clk);
      check("lat_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_valid", 32'(out_valid), 32'd1);
      check("I_instr", out_instr, 32'h00500093);
      check("I_addr", 32'(out_addr), 32'(BASE));
      @(posedge clk);
      #1;
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      expect_word("R", 32'h002081B3, 8'(BASE + 1));
      send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
      expect_word("S", 32'h0020A423, 8'(BASE + 2));
      send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
      expect_word("B", 32'h00208463, 8'(BASE + 3));
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      expect_word("U", 32'h123452B7, 8'(BASE + 4));
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      expect_word("J", 32'h001000EF, 8'(BASE + 5));

      // Rejected bundles: pulses, counter, no word, address untouched
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
      send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      idle(4);
      check("err_pulses", 32'(m_err_seen), 32'd3);
      check("err_count", 32'(err_count), 32'd3);
      send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'($signed(-2048)));
      expect_word("after_err", 32'h80018113, 8'(BASE + 6));

      // Backpressure: two accepted, third stalls, then in-order release
      out_ready = 1'b0;
      enc_a = ref_enc(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
      send(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
      send(3'd1, 7'h13, 5'd7, 5'd8, 5'd0, 3'd4, 7'd0, 32'd2047);
      in_valid  = 1'b1;
      in_format = 3'd2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_instr", out_instr, enc_a);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(3'd2, 7'h23, 5'd0, 5'd9, 5'd10, 3'd2, 7'd0, 32'($signed(-4)));
      idle(5);
      check("bp_drain", 32'(q.size()), 32'd0);

      // Idle address clear
      addr_clear = 1'b1;
      idle(1);
      addr_clear = 1'b0;
      m_addr = BASE;
      send(3'd4, 7'h17, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000);
      expect_word("clr", ref_enc(3'd4, 7'h17, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000), BASE);

      // Clear coincident with a legal advance: word keeps old address
      enc_w = ref_enc(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'($signed(-4096)));
      send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'($signed(-4096)));
      addr_clear = 1'b1;
      m_addr = BASE;
      idle(1);
      addr_clear = 1'b0;
      expect_word("coin_old", enc_w, 8'(BASE + 1));
      enc_w = ref_enc(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574);
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574);
      expect_word("coin_new", enc_w, BASE);

      // Reset with both stages full
      out_ready = 1'b0;
      send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd7, 7'd0, 32'd0);
      send(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd6, 7'd0, 32'd0);
      resetn = 1'b0;
      idle(1);
      resetn = 1'b1;
      q.delete();
      m_addr     = BASE;
      m_err      = 0;
      m_err_seen = 0;
      @(negedge clk);
      check("rst2_out_valid", 32'(out_valid), 32'd0);
      check("rst2_err_count", 32'(err_count), 32'd0);
      check("rst2_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("rst2_out_err", 32'(out_err), 32'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      enc_w = ref_enc(3'd1, 7'h03, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd16);
      send(3'd1, 7'h03, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd16);
      expect_word("rst2_word", enc_w, BASE);

      // Randomized traffic with random sink stalls (crosses the address wrap)
      fork
         begin
            for (int n = 0; n < 700; n++) begin
               send_random();
               idle(int'($urandom_range(0, 1)));
            end
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 9) < 7);
            end
         end
      join
      out_ready = 1'b1;
      for (int c = 0; c < 100 && q.size() != 0; c++) idle(1);
      idle(3);
      check("rand_drain", 32'(q.size()), 32'd0);
      exp_sat = (m_err > 255) ? 255 : m_err;
      check("rand_err_count", 32'(err_count), 32'(exp_sat));
      check("rand_err_pulses", 32'(m_err_seen), 32'(m_err));

      // Saturation of the reject counter
      for (int n = 0; n < 260; n++) send(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
      idle(4);
      check("sat_err_count", 32'(err_count), 32'd255);
      check("sat_err_pulses", 32'(m_err_seen), 32'(m_err));
      check("sat_no_words", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
